// File: rtl/pu_operand_feeder.sv
// Operand feeder for the PU MAC element: two independent operand FIFOs,
// pairwise issue to the PU, and dot-product framing (acc_clr / vec_last).
module pu_operand_feeder #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned VEC_LEN    = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic [DATA_WIDTH-1:0]          a_in,
   input  logic                           a_valid,
   output logic                           a_ready,
   input  logic [DATA_WIDTH-1:0]          b_in,
   input  logic                           b_valid,
   output logic                           b_ready,
   output logic                           en,
   output logic [DATA_WIDTH-1:0]          a,
   output logic [DATA_WIDTH-1:0]          b,
   output logic                           acc_clr,
   output logic                           vec_last,
   output logic [$clog2(VEC_LEN+1)-1:0]   elem_idx
);

   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W = PW + 1;
   localparam int unsigned IW    = $clog2(VEC_LEN + 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   logic [DATA_WIDTH-1:0] a_mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] b_mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [PTR_W-1:0] b_wr_q, b_wr_d, b_rd_q, b_rd_d;

   logic a_full, a_empty, b_full, b_empty;
   logic a_push, b_push, issue;

   state_e                state_q;
   logic [IW-1:0]         elem_idx_q;
   logic                  en_q, acc_clr_q, vec_last_q;
   logic [DATA_WIDTH-1:0] a_q, b_q;

   // Full uses the extra pointer bit; empty is plain pointer equality.
   assign a_full  = (a_wr_q[PW] != a_rd_q[PW]) && (a_wr_q[PW-1:0] == a_rd_q[PW-1:0]);
   assign b_full  = (b_wr_q[PW] != b_rd_q[PW]) && (b_wr_q[PW-1:0] == b_rd_q[PW-1:0]);
   assign a_empty = (a_wr_q == a_rd_q);
   assign b_empty = (b_wr_q == b_rd_q);

   // Ready follows registered occupancy and is forced low while in reset.
   assign a_ready = !reset && !a_full;
   assign b_ready = !reset && !b_full;

   // Flush drops same-cycle pushes and suppresses issue.
   assign a_push = a_valid && a_ready && !flush;
   assign b_push = b_valid && b_ready && !flush;
   assign issue  = !a_empty && !b_empty && !flush;

   // Next-state pointers for both FIFOs.
   always_comb begin
      a_wr_d = a_wr_q + PTR_W'(a_push);
      b_wr_d = b_wr_q + PTR_W'(b_push);
      a_rd_d = a_rd_q + PTR_W'(issue);
      b_rd_d = b_rd_q + PTR_W'(issue);
      if (flush) begin
         a_wr_d = '0;
         b_wr_d = '0;
         a_rd_d = '0;
         b_rd_d = '0;
      end
   end

   // FIFO pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_wr_q <= '0;
         a_rd_q <= '0;
         b_wr_q <= '0;
         b_rd_q <= '0;
      end else begin
         a_wr_q <= a_wr_d;
         a_rd_q <= a_rd_d;
         b_wr_q <= b_wr_d;
         b_rd_q <= b_rd_d;
      end
   end

   // FIFO storage; contents are don't-care while empty so no reset is needed.
   always_ff @(posedge clk) begin
      if (a_push) a_mem_q[a_wr_q[PW-1:0]] <= a_in;
      if (b_push) b_mem_q[b_wr_q[PW-1:0]] <= b_in;
   end

   // Vector framing FSM with registered PU-side outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         elem_idx_q <= '0;
         en_q       <= 1'b0;
         acc_clr_q  <= 1'b0;
         vec_last_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
      end else begin
         en_q       <= 1'b0;
         acc_clr_q  <= 1'b0;
         vec_last_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         if (flush) begin
            state_q    <= ST_IDLE;
            elem_idx_q <= '0;
         end else if (issue) begin
            en_q <= 1'b1;
            a_q  <= a_mem_q[a_rd_q[PW-1:0]];
            b_q  <= b_mem_q[b_rd_q[PW-1:0]];
            case (state_q)
               ST_IDLE: begin
                  acc_clr_q <= 1'b1;
                  if (VEC_LEN == 1) begin
                     vec_last_q <= 1'b1;
                     elem_idx_q <= '0;
                  end else begin
                     elem_idx_q <= IW'(1);
                     state_q    <= ST_ACTIVE;
                  end
               end
               ST_ACTIVE: begin
                  if (elem_idx_q == IW'(VEC_LEN - 1)) begin
                     vec_last_q <= 1'b1;
                     elem_idx_q <= '0;
                     state_q    <= ST_IDLE;
                  end else begin
                     elem_idx_q <= elem_idx_q + IW'(1);
                  end
               end
               default: begin
                  state_q    <= ST_IDLE;
                  elem_idx_q <= '0;
               end
            endcase
         end
      end
   end

   assign en       = en_q;
   assign a        = a_q;
   assign b        = b_q;
   assign acc_clr  = acc_clr_q;
   assign vec_last = vec_last_q;
   assign elem_idx = elem_idx_q;

endmodule
